// File: rtl/array_ops_pkg.sv
// Shared types and helpers for the array select / serialize datapath.
package array_ops_pkg;

  typedef enum logic {ST_IDLE, ST_STREAM} ser_state_t;

  function automatic int row_idx_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/array_row_serializer.sv
// Captures one ROWS x COLS array via valid/ready and emits it one row per beat,
// row 0 first, flagging the last row.
module array_row_serializer
  import array_ops_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  localparam int unsigned ROW_IDX_W = row_idx_width(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_array [ROWS][COLS],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_row [COLS],
  output logic [ROW_IDX_W-1:0] out_row_idx,
  output logic                 out_last
);

  localparam int ROW_W  = int'(COLS * BIT_WIDTH);
  localparam int FLAT_W = int'(ROWS) * ROW_W;
  localparam logic [ROW_IDX_W-1:0] LAST_IDX = ROW_IDX_W'(ROWS - 1);

  // Element [r][c] lives at flat bits (r*COLS + c)*BIT_WIDTH.
  function automatic logic [FLAT_W-1:0] convert_3d_to_1d_array(
    input logic [BIT_WIDTH-1:0] arr [ROWS][COLS]
  );
    logic [FLAT_W-1:0] flat;
    flat = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        flat[(r * int'(COLS) + c) * int'(BIT_WIDTH) +: BIT_WIDTH] = arr[r][c];
      end
    end
    return flat;
  endfunction

  ser_state_t              state_q, state_d;
  logic [ROW_IDX_W-1:0]    row_idx_q, row_idx_d;
  logic [FLAT_W-1:0]       storage_q, storage_d;
  logic [ROW_W-1:0]        row_flat;
  logic                    beat, capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      row_idx_q <= '0;
      storage_q <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      storage_q <= storage_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    storage_d = storage_q;
    beat      = out_valid & out_ready;
    capture   = in_valid & in_ready;
    if (beat) begin
      if (out_last) begin
        state_d   = ST_IDLE;
        row_idx_d = '0;
      end else begin
        row_idx_d = row_idx_q + ROW_IDX_W'(1);
      end
    end
    // A capture on the last beat overrides the return to idle.
    if (capture) begin
      state_d   = ST_STREAM;
      row_idx_d = '0;
      storage_d = convert_3d_to_1d_array(in_array);
    end
  end

  always_comb begin
    out_valid   = (state_q == ST_STREAM);
    out_last    = out_valid & (row_idx_q == LAST_IDX);
    in_ready    = ~out_valid | (out_last & out_ready);
    out_row_idx = row_idx_q;
    row_flat    = storage_q[int'(row_idx_q) * ROW_W +: ROW_W];
    for (int c = 0; c < int'(COLS); c++) begin
      out_row[c] = row_flat[c * int'(BIT_WIDTH) +: BIT_WIDTH];
    end
  end

endmodule

// File: tb/tb_array_row_serializer.sv
// Directed bench: ROWS=3/COLS=2 instance driven from a vector table plus reset
// and ROWS=1/COLS=4 instance for back-to-back single-row frames.
module tb_array_row_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: BIT_WIDTH=4, ROWS=3, COLS=2
  logic       in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b0, out_last_a;
  logic [3:0] in_array_a [3][2];
  logic [3:0] out_row_a [2];
  logic [1:0] out_row_idx_a;

  // Instance B: BIT_WIDTH=4, ROWS=1, COLS=4
  logic       in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b0, out_last_b;
  logic [3:0] in_array_b [1][4];
  logic [3:0] out_row_b [4];
  logic [0:0] out_row_idx_b;

  array_row_serializer #(.BIT_WIDTH(4), .ROWS(3), .COLS(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_array(in_array_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_row(out_row_a), .out_row_idx(out_row_idx_a), .out_last(out_last_a)
  );

  array_row_serializer #(.BIT_WIDTH(4), .ROWS(1), .COLS(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_array(in_array_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_row(out_row_b), .out_row_idx(out_row_idx_b), .out_last(out_last_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Nibble k of the flat value is element [k/2][k%2].
  task automatic set_array_a(input logic [23:0] flat);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++)
        in_array_a[r][c] = flat[(r * 2 + c) * 4 +: 4];
  endtask

  task automatic set_array_b(input logic [15:0] flat);
    for (int c = 0; c < 4; c++) in_array_b[0][c] = flat[c * 4 +: 4];
  endtask

  // {valid, ready, idx, last, row[0], row[1]}
  function automatic logic [31:0] obs_a();
    return {19'd0, out_valid_a, in_ready_a, out_row_idx_a, out_last_a, out_row_a[0], out_row_a[1]};
  endfunction

  function automatic logic [31:0] exp_a(input logic v, input logic r, input logic [1:0] idx,
                                        input logic l, input logic [7:0] row);
    return {19'd0, v, r, idx, l, row};
  endfunction

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [23:0] arr;
    logic        ev;
    logic        er;
    logic [1:0]  eidx;
    logic        el;
    logic [7:0]  erow;
  } vec_t;

  localparam logic [23:0] F1 = 24'h654321;  // rows {1,2},{3,4},{5,6}
  localparam logic [23:0] F2 = 24'hCBA987;  // rows {7,8},{9,A},{B,C}

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic ordy, input logic [23:0] arr,
                              input logic ev, input logic er, input logic [1:0] eidx,
                              input logic el, input logic [7:0] erow);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.arr = arr;
    v.ev = ev; v.er = er; v.eidx = eidx; v.el = el; v.erow = erow;
    return v;
  endfunction

  initial begin
    logic [15:0] prev_b;
    logic [15:0] cur_b;

    // Single frame, out_ready high
    vecs.push_back(mk(0, 1, 0,  0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, F1, 0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0,  1, 0, 0, 0, 8'h12));
    vecs.push_back(mk(0, 1, 0,  1, 0, 1, 0, 8'h34));
    vecs.push_back(mk(0, 1, 0,  1, 1, 2, 1, 8'h56));
    vecs.push_back(mk(0, 1, 0,  0, 1, 0, 0, 8'h12));
    // Backpressure on idx 1 for 4 cycles, in_valid ignored meanwhile
    vecs.push_back(mk(1, 1, F1, 0, 1, 0, 0, 8'h12));
    vecs.push_back(mk(0, 1, 0,  1, 0, 0, 0, 8'h12));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, F2, 1, 0, 1, 0, 8'h34));
    vecs.push_back(mk(0, 1, 0,  1, 0, 1, 0, 8'h34));
    vecs.push_back(mk(0, 1, 0,  1, 1, 2, 1, 8'h56));
    vecs.push_back(mk(0, 1, 0,  0, 1, 0, 0, 8'h12));
    // Back-to-back frames; last beat stalled once before release
    vecs.push_back(mk(1, 1, F1, 0, 1, 0, 0, 8'h12));
    vecs.push_back(mk(1, 1, F2, 1, 0, 0, 0, 8'h12));
    vecs.push_back(mk(1, 1, F2, 1, 0, 1, 0, 8'h34));
    vecs.push_back(mk(1, 1, F2, 1, 1, 2, 1, 8'h56));
    vecs.push_back(mk(0, 1, 0,  1, 0, 0, 0, 8'h78));
    vecs.push_back(mk(0, 1, 0,  1, 0, 1, 0, 8'h9A));
    vecs.push_back(mk(1, 0, F1, 1, 0, 2, 1, 8'hBC));
    vecs.push_back(mk(0, 1, 0,  1, 1, 2, 1, 8'hBC));
    vecs.push_back(mk(0, 1, 0,  0, 1, 0, 0, 8'h78));

    set_array_a('0);
    set_array_b('0);

    #1;
    check("reset_a", obs_a(), exp_a(0, 1, 0, 0, 8'h00));
    check("reset_b", {out_valid_b, in_ready_b, out_last_b, out_row_idx_b},
          {1'b0, 1'b1, 1'b0, 1'b0});

    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid_a  = vecs[i].iv;
      out_ready_a = vecs[i].ordy;
      set_array_a(vecs[i].arr);
      #1;
      check($sformatf("vec%0d", i), obs_a(),
            exp_a(vecs[i].ev, vecs[i].er, vecs[i].eidx, vecs[i].el, vecs[i].erow));
    end

    // Reset mid-frame at idx 1, then a fresh frame starts at idx 0
    @(negedge clk);
    in_valid_a = 1'b1; out_ready_a = 1'b1; set_array_a(F2);
    @(negedge clk);
    in_valid_a = 1'b0;
    #1 check("rst_pre_idx0", obs_a(), exp_a(1, 0, 0, 0, 8'h78));
    @(negedge clk);
    #1 check("rst_pre_idx1", obs_a(), exp_a(1, 0, 1, 0, 8'h9A));
    #1 rst = 1'b1;
    #1 check("rst_async", obs_a(), exp_a(0, 1, 0, 0, 8'h00));
    @(negedge clk);
    rst = 1'b0;
    in_valid_a = 1'b1; set_array_a(F1);
    @(negedge clk);
    in_valid_a = 1'b0;
    #1 check("rst_new_idx0", obs_a(), exp_a(1, 0, 0, 0, 8'h12));
    @(negedge clk);
    #1 check("rst_new_idx1", obs_a(), exp_a(1, 0, 1, 0, 8'h34));

    // ROWS=1: five frames in five cycles, every beat last
    out_ready_b = 1'b1;
    prev_b = '0;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      cur_b = {4'(i + 3), 4'(i + 2), 4'(i + 1), 4'(i)};
      in_valid_b = (i < 5);
      set_array_b(cur_b);
      #1;
      if (i > 0) begin
        check($sformatf("b_frame%0d", i - 1),
              {out_valid_b, in_ready_b, out_last_b, out_row_idx_b,
               out_row_b[3], out_row_b[2], out_row_b[1], out_row_b[0]},
              {1'b1, 1'b1, 1'b1, 1'b0, prev_b});
      end
      prev_b = cur_b;
    end
    @(negedge clk);
    #1 check("b_idle", {out_valid_b, in_ready_b, out_last_b}, {1'b0, 1'b1, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
